// File: rtl/frame_stream_gen_pkg.sv
// Shared types and constants for the frame stream generator.
// Holds the timing-state enum, the counter width and a frame-period helper.
// The helper gives the cycle count of one frame when generation runs back to back.
package frame_stream_gen_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_V_FRONT,
    ST_ACTIVE,
    ST_H_BLANK,
    ST_V_BACK,
    ST_V_GAP
  } state_t;

  // Cycles from one V_FRONT entry to the next with i_en held high.
  function automatic int frame_period(input int w, input int h, input int hb,
                                      input int vf, input int vb, input int vg);
    return vf + h * w + (h - 1) * hb + vb + vg;
  endfunction

endpackage

// File: rtl/frame_stream_gen_timing_fsm.sv
// Frame timing sequencer: walks IDLE/V_FRONT/ACTIVE/H_BLANK/V_BACK/V_GAP.
// Ports: i_clk, i_rst_n (async active-low), en (start/continue), state,
//        col (cycle count inside the current state, = column in ACTIVE), row.
module frame_timing_fsm
  import frame_stream_gen_pkg::*;
#(
  parameter int P_IMAGE_WIDTH  = 320,
  parameter int P_IMAGE_HEIGHT = 256,
  parameter int P_H_BLANK      = 16,
  parameter int P_V_FRONT      = 8,
  parameter int P_V_BACK       = 8,
  parameter int P_V_GAP        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             en,
  output state_t           state,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row
);

  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(P_IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(P_IMAGE_HEIGHT - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(P_H_BLANK - 1);
  localparam logic [CNT_W-1:0] VF_LAST = CNT_W'(P_V_FRONT - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(P_V_BACK - 1);
  localparam logic [CNT_W-1:0] VG_LAST = CNT_W'(P_V_GAP - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          col <= '0;
          if (en) state <= ST_V_FRONT;
        end
        ST_V_FRONT: begin
          row <= '0;
          if (col == VF_LAST) begin
            col   <= '0;
            state <= ST_ACTIVE;
          end else begin
            col <= col + ONE;
          end
        end
        ST_ACTIVE: begin
          if (col == W_LAST) begin
            col <= '0;
            if (row == H_LAST) begin
              state <= ST_V_BACK;
            end else begin
              row   <= row + ONE;
              state <= ST_H_BLANK;
            end
          end else begin
            col <= col + ONE;
          end
        end
        ST_H_BLANK: begin
          if (col == HB_LAST) begin
            col   <= '0;
            state <= ST_ACTIVE;
          end else begin
            col <= col + ONE;
          end
        end
        ST_V_BACK: begin
          if (col == VB_LAST) begin
            col   <= '0;
            state <= ST_V_GAP;
          end else begin
            col <= col + ONE;
          end
        end
        ST_V_GAP: begin
          // i_en is only looked at here and in IDLE, so a frame in flight always completes.
          if (col == VG_LAST) begin
            col   <= '0;
            state <= en ? ST_V_FRONT : ST_IDLE;
          end else begin
            col <= col + ONE;
          end
        end
        default: begin
          col   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_stream_gen.sv
// Pixel stream transmitter: pulls pixels over valid/ready, emits h_sync/v_sync/data frames.
// Ports: i_clk, i_rst_n (async active-low), i_en, i_valid/i_data/o_ready upstream,
//        o_h_sync/o_v_sync/o_data/o_frame_done/o_underflow downstream (all registered).
// Optional: FRAME_STREAM_TEST_PATTERN_EN adds i_pattern_sel (col+row ramp instead of upstream data).
module frame_stream_gen
  import frame_stream_gen_pkg::*;
#(
  parameter int P_DATA_WIDTH   = 20,
  parameter int P_IMAGE_WIDTH  = 320,
  parameter int P_IMAGE_HEIGHT = 256,
  parameter int P_H_BLANK      = 16,
  parameter int P_V_FRONT      = 8,
  parameter int P_V_BACK       = 8,
  parameter int P_V_GAP        = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [P_DATA_WIDTH-1:0] i_data,
  output logic                    o_ready,
  output logic                    o_h_sync,
  output logic                    o_v_sync,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic                    o_frame_done,
  output logic                    o_underflow
`ifdef FRAME_STREAM_TEST_PATTERN_EN
  ,
  input  logic                    i_pattern_sel
`endif
);

  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(P_V_BACK - 1);

  state_t                  state;
  logic [CNT_W-1:0]        col;
  logic [CNT_W-1:0]        row;
  logic                    active;
  logic [P_DATA_WIDTH-1:0] data_nxt;
  logic                    miss;

  frame_timing_fsm #(
    .P_IMAGE_WIDTH (P_IMAGE_WIDTH),
    .P_IMAGE_HEIGHT(P_IMAGE_HEIGHT),
    .P_H_BLANK     (P_H_BLANK),
    .P_V_FRONT     (P_V_FRONT),
    .P_V_BACK      (P_V_BACK),
    .P_V_GAP       (P_V_GAP)
  ) u_timing (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .en     (i_en),
    .state  (state),
    .col    (col),
    .row    (row)
  );

  assign active = (state == ST_ACTIVE);

`ifdef FRAME_STREAM_TEST_PATTERN_EN
  logic             pattern_mode;
  logic [CNT_W:0]   pat_sum;

  // Keep re-sampling while the generator sits between frames; the value present on the
  // cycle that enters V_FRONT is therefore the one held for the whole frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pattern_mode <= 1'b0;
    end else if (state == ST_IDLE || state == ST_V_GAP) begin
      pattern_mode <= i_pattern_sel;
    end
  end

  assign pat_sum = {1'b0, col} + {1'b0, row};
  assign o_ready = active && !pattern_mode;
`else
  logic unused_row;

  // row only feeds the test pattern ramp.
  assign unused_row = ^row;
  assign o_ready    = active;
`endif

  always_comb begin
    data_nxt = '0;
    miss     = 1'b0;
    if (active) begin
`ifdef FRAME_STREAM_TEST_PATTERN_EN
      if (pattern_mode) data_nxt = P_DATA_WIDTH'(pat_sum);
      else
`endif
      if (i_valid) data_nxt = i_data;
      else         miss     = 1'b1;
    end
  end

  // Outputs trail the timing state by one cycle; the line length never depends on i_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_v_sync     <= 1'b0;
      o_h_sync     <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      o_v_sync     <= state inside {ST_V_FRONT, ST_ACTIVE, ST_H_BLANK, ST_V_BACK};
      o_h_sync     <= active;
      o_data       <= data_nxt;
      o_frame_done <= (state == ST_V_BACK) && (col == VB_LAST);
      if (state == ST_V_FRONT) o_underflow <= 1'b0;
      else if (miss)           o_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/frame_stream_gen.md
Name: frame_stream_gen

Overview:
- Transmitter side of the h_sync/v_sync/data pixel stream used by the edge-flagging and windowing blocks.
- Pulls pixels from an upstream source over a valid/ready handshake.
- Emits frames with fixed, parameterised line/frame blanking. h_sync is high for exactly P_IMAGE_WIDTH contiguous cycles per line, and v_sync brackets the whole frame, so downstream edge detection sees clean edges.
- Sits between a pixel FIFO/DDR reader and the processing chain.

Parameters:
- P_DATA_WIDTH, 20, pixel width.
- P_IMAGE_WIDTH, 320, active pixels per line (>=1).
- P_IMAGE_HEIGHT, 256, lines per frame (>=1).
- P_H_BLANK, 16, h_sync-low cycles between lines inside a frame (>=1).
- P_V_FRONT, 8, cycles with v_sync high and h_sync low before the first line (>=1).
- P_V_BACK, 8, cycles with v_sync high and h_sync low after the last line (>=1).
- P_V_GAP, 32, v_sync-low cycles between frames (>=1).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_en  in  1  start/continue frame generation
- i_valid  in  1  upstream pixel valid
- i_data  in  P_DATA_WIDTH  upstream pixel
- o_ready  out  1  pixel accepted this cycle when i_valid&&o_ready
- o_h_sync  out  1  line valid
- o_v_sync  out  1  frame valid
- o_data  out  P_DATA_WIDTH  pixel
- o_frame_done  out  1  one-cycle pulse on the last V_BACK cycle
- o_underflow  out  1  sticky: a pixel was missing during an active line
- i_pattern_sel  in  1  (only with FRAME_STREAM_TEST_PATTERN_EN)

Interface decision: reset i_rst_n, asynchronous, active-low; clock i_clk.

Behaviour:
- State machine (registered): IDLE, V_FRONT, ACTIVE, H_BLANK, V_BACK, V_GAP.
- Cycle counter: 16 bit. Row counter: 16 bit.
- IDLE: when i_en is sampled high, go to V_FRONT. Otherwise stay in IDLE.
- V_FRONT: after P_V_FRONT cycles, go to ACTIVE. Clear the column and row counters and clear o_underflow.
- ACTIVE: runs P_IMAGE_WIDTH cycles.
  - Then, if row == P_IMAGE_HEIGHT-1, go to V_BACK.
  - Otherwise go to H_BLANK and increment row.
- H_BLANK: after P_H_BLANK cycles, go to ACTIVE.
- V_BACK: after P_V_BACK cycles, go to V_GAP. o_frame_done pulses on the final V_BACK cycle.
- V_GAP: after P_V_GAP cycles, go to V_FRONT if i_en is high, else IDLE.
- i_en is sampled only in IDLE and at the end of V_GAP. Deasserting i_en mid-frame never truncates the frame.
- o_ready is combinational: (state==ACTIVE).
- Output registers update every cycle from the current state:
  - o_v_sync <= state in {V_FRONT, ACTIVE, H_BLANK, V_BACK}.
  - o_h_sync <= state==ACTIVE.
  - o_data <= i_data if ACTIVE && i_valid.
  - o_data <= 0 if ACTIVE && !i_valid; o_underflow also sets in this case.
  - o_data <= 0 outside ACTIVE.
- Latency:
  - Accepted pixel appears on o_data one cycle after the handshake.
  - o_v_sync rises 2 cycles after the first cycle in which i_en is sampled high in IDLE.
- Timing is never stretched by underflow. A line is always exactly P_IMAGE_WIDTH h_sync-high cycles.
- Frame period with i_en held high: P_V_FRONT + H*W + (H-1)*P_H_BLANK + P_V_BACK + P_V_GAP cycles, where H = P_IMAGE_HEIGHT and W = P_IMAGE_WIDTH.
- Reset values: all outputs 0, state IDLE, counters 0. Reset asserted mid-frame drops o_v_sync and o_h_sync immediately (async).
- o_underflow stays high until the next frame's V_FRONT.

Optional Feature:
- Macro: FRAME_STREAM_TEST_PATTERN_EN.
- With the macro defined, port i_pattern_sel exists. When i_pattern_sel=1 (sampled at V_FRONT entry and held for the frame):
  - o_ready stays 0 and i_valid/i_data are ignored.
  - o_data = zero-extended (col + row) truncated to P_DATA_WIDTH.
  - o_underflow never sets.
- Without the macro: no port, no pattern logic; behaviour is as for i_pattern_sel=0.

Decomposition:
- Shared package holds:
  - the state enum (IDLE..V_GAP);
  - the 16-bit counter width constant;
  - a frame-period helper function used by testbenches.
- One natural sub-module: frame_timing_fsm. It contains the state and counters, and outputs state/col/row. The top level adds the handshake, data mux and output registers.

Test Plan:
Params for all tests: W=4, H=3, H_BLANK=2, V_FRONT=2, V_BACK=2, V_GAP=3, i_valid tied 1.
- Single frame: i_en=1 pulse -> exactly 3 h_sync bursts of 4 cycles separated by 2 low cycles; v_sync high 20 cycles; o_frame_done pulses once, on the last v_sync-high cycle.
- Continuous i_en=1 -> v_sync rising edges exactly 23 cycles apart; 12 handshakes per frame; data 1..12 from an incrementing source appears in order.
- Underflow: i_valid=0 on the 2nd pixel of line 1 -> that o_data=0, h_sync still 4 cycles, o_underflow=1 until the next V_FRONT, then 0.
- i_en dropped during line 2 -> frame completes all 3 lines, then IDLE with v_sync=0 held.
- Reset asserted mid-ACTIVE -> all outputs 0 immediately. After release with i_en=1, a clean full frame follows.
- With FRAME_STREAM_TEST_PATTERN_EN and i_pattern_sel=1 -> line 0 data 0,1,2,3; line 2 data 2,3,4,5; o_ready never high.
